imem_loadable: RTL and testbench



---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_ram_1r1w.sv | 39 +++
 rtl/imem_loadable.sv | 120 ++++++++++++
 tb/tb_imem_loadable.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and instruction constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD
  } imem_state_t;

  // Filler for benches padding hazard programs, and the end-of-program marker.
  localparam logic [31:0] NOP_ADD_XZR  = 32'h8b1f03ff;
  localparam logic [31:0] HALT_CBZ_XZR = 32'hb400001f;

endpackage

// File: rtl/imem_ram_1r1w.sv
// N x 2**ADDR_W storage with one registered read port and one synchronous write port.
module imem_ram_1r1w #(
  parameter int unsigned  N      = 32,
  parameter int unsigned  ADDR_W = 7,
  parameter logic [N-1:0] FILL   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [N-1:0]      rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [N-1:0]      wdata_i
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Array is never reset; it powers up holding FILL in every word.
  logic [N-1:0] mem_q [Depth] = '{default: FILL};
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with 1-cycle fetch and a clear-then-stream reload sequencer.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned  N      = 32,
  parameter int unsigned  ADDR_W = 7,
  parameter logic [N-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [N-1:0]      load_data,
  output logic              load_ready,
  output logic              load_done
);

  localparam logic [ADDR_W:0] DepthW = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PtrOne = 1;

  imem_state_t     state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            done_q, done_d;
  logic            q_valid_q;

  logic            rd_en;
  logic            wr_en;
  logic [N-1:0]    wr_data;

  assign rd_en = (state_q == IDLE) && fetch_en;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = FILL;
    load_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
          len_d   = (load_len > DepthW) ? DepthW : load_len;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + PtrOne;
        if (ptr_q == DepthW - PtrOne) begin
          ptr_d = '0;
          // A zero-length load finishes straight out of the clear phase.
          if (len_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        load_ready = (ptr_q < len_q);
        wr_data    = load_data;
        if (load_valid && load_ready) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + PtrOne;
          if (ptr_q + PtrOne == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      q_valid_q <= rd_en;
    end
  end

  imem_ram_1r1w #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .FILL   (FILL)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .re_i    (rd_en),
    .raddr_i (addr),
    .rdata_o (q),
    .we_i    (wr_en),
    .waddr_i (ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data)
  );

  assign q_valid   = q_valid_q;
  assign busy      = (state_q != IDLE);
  assign load_done = done_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: fetch latency, clear/load sequencing, edge lengths, reset abort.
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 7;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          fetch_en   = 1'b0;
  logic [AW-1:0] addr       = '0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len   = '0;
  logic          load_valid = 1'b0;
  logic [N-1:0]  load_data  = '0;
  logic [N-1:0]  q;
  logic          q_valid;
  logic          busy;
  logic          load_ready;
  logic          load_done;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] wbuf [256];
  int busy_n, done_n, acc_n, rdy_n;

  always #5 clk = ~clk;

  imem_loadable #(
    .N      (N),
    .ADDR_W (AW),
    .FILL   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .addr       (addr),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    fetch_en = 1'b1;
    addr     = a;
    tick();
    fetch_en = 1'b0;
    chk({tag, "_q"}, q, exp);
    chk({tag, "_qv"}, 32'(q_valid), 32'd1);
  endtask

  // Runs from the current busy phase until the sequencer returns to IDLE.
  task automatic drain(input logic [3:0] vpat);
    int idx = 0;
    int guard = 0;
    logic [1:0] ph = 2'd0;
    logic acc;
    busy_n = 0; done_n = 0; acc_n = 0; rdy_n = 0;
    load_data = wbuf[0];
    while (busy && guard < 2000) begin
      load_valid = vpat[ph];
      if (load_done) done_n++;
      acc = load_ready && load_valid;
      if (load_ready) begin
        rdy_n++;
        ph++;
      end
      if (acc) acc_n++;
      busy_n++;
      guard++;
      tick();
      if (acc) begin
        idx++;
        load_data = wbuf[idx];
      end
    end
    load_valid = 1'b0;
    chk("drain_busy_fell", 32'(busy), 32'd0);
    chk("done_after_last", 32'(load_done), 32'd1);
    chk("ready_after_last", 32'(load_ready), 32'd0);
    if (load_done) done_n++;
    tick();
    if (load_done) done_n++;
    tick();
    if (load_done) done_n++;
  endtask

  task automatic run_load(input int len, input logic [3:0] vpat);
    load_start = 1'b1;
    load_len   = len[AW:0];
    tick();
    load_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    drain(vpat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset state and basic fetch
    tick();
    tick();
    chk("rst_q", q, 32'h0);
    chk("rst_qv", 32'(q_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    tick();
    fetch_en = 1'b1;
    addr = 7'd0;   tick(); chk("f0_q", q, 32'h0); chk("f0_qv", 32'(q_valid), 32'd1);
    addr = 7'd5;   tick(); chk("f5_q", q, 32'h0); chk("f5_qv", 32'(q_valid), 32'd1);
    addr = 7'd127; tick(); chk("f127_q", q, 32'h0); chk("f127_qv", 32'(q_valid), 32'd1);
    fetch_en = 1'b0;
    tick();
    chk("idle_qv", 32'(q_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2. Plain three-word load
    wbuf[0] = 32'hf8000001; wbuf[1] = 32'hf8008002; wbuf[2] = HALT_CBZ_XZR;
    run_load(3, 4'b1111);
    chk("t2_busy_cycles", busy_n, 32'd131);
    chk("t2_accepts", acc_n, 32'd3);
    chk("t2_done_count", done_n, 32'd1);
    fetch(7'd0, 32'hf8000001, "t2_m0");
    fetch(7'd1, 32'hf8008002, "t2_m1");
    fetch(7'd2, 32'hb400001f, "t2_m2");
    fetch(7'd3, 32'h0, "t2_m3");

    // 6. Fetch and load_start together; second start during CLEAR ignored
    fetch_en = 1'b1; addr = 7'd1; load_start = 1'b1; load_len = 8'd2;
    tick();
    fetch_en = 1'b0; load_start = 1'b0;
    chk("t6_q", q, 32'hf8008002);
    chk("t6_qv", 32'(q_valid), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    fetch_en = 1'b1; addr = 7'd0;
    tick();
    fetch_en = 1'b0;
    chk("t6_busy_fetch_qv", 32'(q_valid), 32'd0);
    chk("t6_busy_fetch_hold", q, 32'hf8008002);
    load_start = 1'b1; load_len = 8'd5;
    tick();
    load_start = 1'b0;
    wbuf[0] = NOP_ADD_XZR; wbuf[1] = HALT_CBZ_XZR; wbuf[2] = 32'hdead0002;
    drain(4'b1111);
    chk("t6_done_count", done_n, 32'd1);
    chk("t6_accepts", acc_n, 32'd2);
    fetch(7'd0, 32'h8b1f03ff, "t6_m0");
    fetch(7'd1, 32'hb400001f, "t6_m1");
    fetch(7'd2, 32'h0, "t6_m2");

    // 3. Throttled load, valid pattern 1,0,0,1
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333;
    run_load(2, 4'b1001);
    chk("t3_busy_cycles", busy_n, 32'd132);
    chk("t3_ready_cycles", rdy_n, 32'd4);
    chk("t3_accepts", acc_n, 32'd2);
    chk("t3_done_count", done_n, 32'd1);
    fetch(7'd0, 32'h11111111, "t3_m0");
    fetch(7'd1, 32'h22222222, "t3_m1");
    fetch(7'd2, 32'h0, "t3_m2");

    // 4a. Zero-length load
    run_load(0, 4'b1111);
    chk("t4a_busy_cycles", busy_n, 32'd128);
    chk("t4a_ready_cycles", rdy_n, 32'd0);
    chk("t4a_done_count", done_n, 32'd1);
    fetch(7'd0, 32'h0, "t4a_m0");
    fetch(7'd1, 32'h0, "t4a_m1");

    // 4b. Oversized length saturates to depth
    for (int i = 0; i < 256; i++) wbuf[i] = 32'ha5000000 | 32'(i);
    run_load(200, 4'b1111);
    chk("t4b_busy_cycles", busy_n, 32'd256);
    chk("t4b_ready_cycles", rdy_n, 32'd128);
    chk("t4b_accepts", acc_n, 32'd128);
    chk("t4b_done_count", done_n, 32'd1);
    fetch(7'd0, 32'ha5000000, "t4b_m0");
    fetch(7'd64, 32'ha5000040, "t4b_m64");
    fetch(7'd127, 32'ha500007f, "t4b_m127");

    // 5. Reset in the middle of LOAD after one accepted word
    load_start = 1'b1; load_len = 8'd4;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 300 && !load_ready; k++) tick();
    chk("t5_reached_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 32'hcafe0001;
    tick();
    load_valid = 1'b0;
    chk("t5_still_ready", 32'(load_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_ready", 32'(load_ready), 32'd0);
    chk("t5_async_done", 32'(load_done), 32'd0);
    tick();
    chk("t5_rst_q", q, 32'h0);
    reset = 1'b0;
    tick();
    chk("t5_no_done", 32'(load_done), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    fetch(7'd0, 32'hcafe0001, "t5_m0");
    fetch(7'd1, 32'h0, "t5_m1");
    fetch(7'd3, 32'h0, "t5_m3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
